// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: executes ALU writebacks directly and word/byte loads and stores
// over a request/grant/rvalid data-memory port, producing one registered writeback strobe
// per instruction. Back-pressures execute while a memory access is in flight.
// Optional feature macro: MEM_WB_BYTE_OPS_EN enables LBU/SB byte lanes; when undefined,
// LBU executes as LW and SB as SW.
module mem_wb_stage #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              n_reset_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [2:0]        op_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic [31:0]       result_i,
   input  logic [31:0]       store_data_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [3:0]        dmem_be_o,
   output logic [31:0]       dmem_wdata_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [31:0]       dmem_rdata_i,
   output logic              wb_we_o,
   output logic [REG_AW-1:0] wb_addr_o,
   output logic [31:0]       wb_data_o,
   output logic              misalign_o
);

   localparam logic [2:0] OpAlu = 3'd1;
   localparam logic [2:0] OpLw  = 3'd2;
   localparam logic [2:0] OpLbu = 3'd3;
   localparam logic [2:0] OpSw  = 3'd4;
   localparam logic [2:0] OpSb  = 3'd5;

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

   state_t            state;
   logic              pend_load;
   logic [REG_AW-1:0] pend_rd;

   logic              is_alu;
   logic              is_mem;
   logic              is_load;
   logic [3:0]        req_be;
   logic [31:0]       req_wdata;
   logic              misalign_next;
   logic [31:0]       load_data;

`ifdef MEM_WB_BYTE_OPS_EN
   logic              is_byte;
   logic              pend_byte;
   logic [1:0]        pend_lane;
`endif

   // Decode the incoming op class; codes 6-7 fall through as NONE.
   always_comb begin
      is_alu  = 1'b0;
      is_mem  = 1'b0;
      is_load = 1'b0;
`ifdef MEM_WB_BYTE_OPS_EN
      is_byte = 1'b0;
`endif
      case (op_i)
         OpAlu: is_alu = 1'b1;
         OpLw: begin
            is_mem  = 1'b1;
            is_load = 1'b1;
         end
         OpLbu: begin
            is_mem  = 1'b1;
            is_load = 1'b1;
`ifdef MEM_WB_BYTE_OPS_EN
            is_byte = 1'b1;
`endif
         end
         OpSw: is_mem = 1'b1;
         OpSb: begin
            is_mem = 1'b1;
`ifdef MEM_WB_BYTE_OPS_EN
            is_byte = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // Byte enables, write data and misalignment flag for the request being accepted.
   always_comb begin
      req_be        = 4'hF;
      req_wdata     = store_data_i;
      misalign_next = is_mem & (result_i[1:0] != 2'b00);
`ifdef MEM_WB_BYTE_OPS_EN
      if (is_byte) begin
         req_be        = 4'b0001 << result_i[1:0];
         req_wdata     = {4{store_data_i[7:0]}};
         misalign_next = 1'b0;
      end
`endif
   end

   // Load return data, zero-extended from the addressed lane for LBU.
   always_comb begin
      load_data = dmem_rdata_i;
`ifdef MEM_WB_BYTE_OPS_EN
      if (pend_byte) begin
         load_data = {24'b0, dmem_rdata_i[{pend_lane, 3'b000} +: 8]};
      end
`endif
   end

   // Stage FSM with all outputs registered; gnt/rvalid outside their state are ignored.
   always_ff @(posedge clk or negedge n_reset_i) begin
      if (!n_reset_i) begin
         state        <= StIdle;
         ready_o      <= 1'b1;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_be_o    <= 4'h0;
         dmem_wdata_o <= 32'h0;
         wb_we_o      <= 1'b0;
         wb_addr_o    <= '0;
         wb_data_o    <= 32'h0;
         misalign_o   <= 1'b0;
         pend_load    <= 1'b0;
         pend_rd      <= '0;
`ifdef MEM_WB_BYTE_OPS_EN
         pend_byte    <= 1'b0;
         pend_lane    <= 2'b00;
`endif
      end else begin
         wb_we_o    <= 1'b0;
         misalign_o <= 1'b0;
         case (state)
            StIdle: begin
               if (valid_i) begin
                  misalign_o <= misalign_next;
                  if (is_alu) begin
                     wb_we_o   <= 1'b1;
                     wb_addr_o <= rd_addr_i;
                     wb_data_o <= result_i;
                  end else if (is_mem) begin
                     state        <= StReq;
                     ready_o      <= 1'b0;
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= ~is_load;
                     dmem_addr_o  <= {result_i[ADDR_W-1:2], 2'b00};
                     dmem_be_o    <= req_be;
                     dmem_wdata_o <= req_wdata;
                     pend_load    <= is_load;
                     pend_rd      <= rd_addr_i;
`ifdef MEM_WB_BYTE_OPS_EN
                     pend_byte    <= is_byte;
                     pend_lane    <= result_i[1:0];
`endif
                  end
               end
            end
            StReq: begin
               if (dmem_gnt_i) begin
                  dmem_req_o <= 1'b0;
                  if (pend_load) begin
                     state <= StWait;
                  end else begin
                     state   <= StIdle;
                     ready_o <= 1'b1;
                  end
               end
            end
            StWait: begin
               if (dmem_rvalid_i) begin
                  state     <= StIdle;
                  ready_o   <= 1'b1;
                  wb_we_o   <= 1'b1;
                  wb_addr_o <= pend_rd;
                  wb_data_o <= load_data;
               end
            end
            default: begin
               state      <= StIdle;
               ready_o    <= 1'b1;
               dmem_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed test-plan steps followed by random
// transactions, each compared against a behavioural model of the stage's rules.
module tb_mem_wb_stage;

   localparam int REG_AW = 5;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              n_reset_i = 1'b0;
   logic              valid_i = 1'b0;
   logic              ready_o;
   logic [2:0]        op_i = 3'd0;
   logic [REG_AW-1:0] rd_addr_i = '0;
   logic [31:0]       result_i = 32'h0;
   logic [31:0]       store_data_i = 32'h0;
   logic              dmem_req_o;
   logic              dmem_we_o;
   logic [ADDR_W-1:0] dmem_addr_o;
   logic [3:0]        dmem_be_o;
   logic [31:0]       dmem_wdata_o;
   logic              dmem_gnt_i = 1'b0;
   logic              dmem_rvalid_i = 1'b0;
   logic [31:0]       dmem_rdata_i = 32'h0;
   logic              wb_we_o;
   logic [REG_AW-1:0] wb_addr_o;
   logic [31:0]       wb_data_o;
   logic              misalign_o;

   int checks = 0;
   int failures = 0;

   mem_wb_stage #(.REG_AW(REG_AW), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .n_reset_i    (n_reset_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .op_i         (op_i),
      .rd_addr_i    (rd_addr_i),
      .result_i     (result_i),
      .store_data_i (store_data_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_gnt_i   (dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i),
      .dmem_rdata_i (dmem_rdata_i),
      .wb_we_o      (wb_we_o),
      .wb_addr_o    (wb_addr_o),
      .wb_data_o    (wb_data_o),
      .misalign_o   (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference rules of the stage, in plain arithmetic.
   function automatic bit m_is_mem(input int op);
      return op >= 2 && op <= 5;
   endfunction

   function automatic bit m_is_load(input int op);
      return op == 2 || op == 3;
   endfunction

   function automatic bit m_byte(input int op);
`ifdef MEM_WB_BYTE_OPS_EN
      return op == 3 || op == 5;
`else
      return (op < 0);
`endif
   endfunction

   function automatic logic [31:0] m_be(input int op, input logic [31:0] addr);
      if (m_byte(op)) return 32'(1 << (addr % 4));
      return 32'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input int op, input logic [31:0] sd);
      if (m_byte(op)) return (sd & 32'hFF) * 32'h0101_0101;
      return sd;
   endfunction

   function automatic logic [31:0] m_load(input int op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      if (m_byte(op)) return (rdata >> (8 * (addr % 4))) & 32'hFF;
      return rdata;
   endfunction

   function automatic logic [31:0] m_misalign(input int op, input logic [31:0] addr);
      return 32'(m_is_mem(op) && !m_byte(op) && (addr % 4) != 0);
   endfunction

   // Runs one instruction end to end; starts and ends on a falling edge with the stage idle.
   task automatic do_op(input int op, input logic [4:0] rd, input logic [31:0] res,
                        input logic [31:0] sd, input int gd, input int rvd,
                        input logic [31:0] rdata);
      logic [31:0] exp_addr;
      exp_addr = res & 32'hFFFF_FFFC;
      check("ready_idle", 32'(ready_o), 32'd1);
      valid_i      = 1'b1;
      op_i         = op[2:0];
      rd_addr_i    = rd;
      result_i     = res;
      store_data_i = sd;
      @(negedge clk);
      valid_i      = 1'b0;
      op_i         = 3'($urandom);
      result_i     = $urandom;
      store_data_i = $urandom;
      check("misalign_pulse", 32'(misalign_o), m_misalign(op, res));
      if (op == 1) begin
         check("alu_wb_we", 32'(wb_we_o), 32'd1);
         check("alu_wb_addr", 32'(wb_addr_o), 32'(rd));
         check("alu_wb_data", wb_data_o, res);
         check("alu_ready", 32'(ready_o), 32'd1);
         return;
      end
      if (!m_is_mem(op)) begin
         check("none_wb_we", 32'(wb_we_o), 32'd0);
         check("none_req", 32'(dmem_req_o), 32'd0);
         check("none_ready", 32'(ready_o), 32'd1);
         return;
      end
      check("req", 32'(dmem_req_o), 32'd1);
      check("we", 32'(dmem_we_o), 32'(!m_is_load(op)));
      check("addr", 32'(dmem_addr_o), exp_addr);
      check("be", 32'(dmem_be_o), m_be(op, res));
      check("wdata", dmem_wdata_o, m_wdata(op, sd));
      check("ready_req", 32'(ready_o), 32'd0);
      check("req_no_wb", 32'(wb_we_o), 32'd0);
      for (int i = 0; i < gd; i++) begin
         dmem_rvalid_i = 1'b1;  // stray rvalid while requesting must be ignored
         dmem_rdata_i  = $urandom;
         @(negedge clk);
         dmem_rvalid_i = 1'b0;
         check("req_hold", 32'(dmem_req_o), 32'd1);
         check("addr_hold", 32'(dmem_addr_o), exp_addr);
         check("be_hold", 32'(dmem_be_o), m_be(op, res));
         check("wdata_hold", dmem_wdata_o, m_wdata(op, sd));
         check("ready_hold", 32'(ready_o), 32'd0);
         check("hold_no_wb", 32'(wb_we_o), 32'd0);
         check("misalign_single", 32'(misalign_o), 32'd0);
      end
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      dmem_gnt_i = 1'b0;
      check("misalign_after", 32'(misalign_o), 32'd0);
      check("req_after_gnt", 32'(dmem_req_o), 32'd0);
      check("gnt_no_wb", 32'(wb_we_o), 32'd0);
      if (!m_is_load(op)) begin
         check("store_ready", 32'(ready_o), 32'd1);
         return;
      end
      check("wait_ready", 32'(ready_o), 32'd0);
      for (int i = 0; i < rvd - 1; i++) begin
         dmem_gnt_i = 1'b1;  // stray grant while waiting must be ignored
         @(negedge clk);
         dmem_gnt_i = 1'b0;
         check("wait_ready_hold", 32'(ready_o), 32'd0);
         check("wait_no_wb", 32'(wb_we_o), 32'd0);
         check("wait_no_req", 32'(dmem_req_o), 32'd0);
      end
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = $urandom;
      check("load_wb_we", 32'(wb_we_o), 32'd1);
      check("load_wb_addr", 32'(wb_addr_o), 32'(rd));
      check("load_wb_data", wb_data_o, m_load(op, res, rdata));
      check("load_ready", 32'(ready_o), 32'd1);
      @(negedge clk);
      check("load_wb_pulse", 32'(wb_we_o), 32'd0);
   endtask

   initial begin
      // Reset values.
      @(negedge clk);
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_req", 32'(dmem_req_o), 32'd0);
      check("rst_we", 32'(dmem_we_o), 32'd0);
      check("rst_addr", 32'(dmem_addr_o), 32'd0);
      check("rst_be", 32'(dmem_be_o), 32'd0);
      check("rst_wdata", dmem_wdata_o, 32'd0);
      check("rst_wb_we", 32'(wb_we_o), 32'd0);
      check("rst_wb_addr", 32'(wb_addr_o), 32'd0);
      check("rst_wb_data", wb_data_o, 32'd0);
      check("rst_misalign", 32'(misalign_o), 32'd0);
      n_reset_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_no_req", 32'(dmem_req_o), 32'd0);
      end

      // Three back-to-back ALU ops.
      valid_i = 1'b1;
      op_i    = 3'd1;
      for (int i = 1; i <= 4; i++) begin
         if (i <= 3) begin
            rd_addr_i = 5'(i);
            result_i  = 32'(i) * 32'h11;
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk);
         if (i <= 3) begin
            check("stream_wb_we", 32'(wb_we_o), 32'd1);
            check("stream_wb_addr", 32'(wb_addr_o), 32'(i));
            check("stream_wb_data", wb_data_o, 32'(i) * 32'h11);
            check("stream_ready", 32'(ready_o), 32'd1);
         end else begin
            check("stream_end_wb_we", 32'(wb_we_o), 32'd0);
         end
      end

      // Directed memory ops from the plan.
      do_op(2, 5'd9, 32'h100, 32'h0, 2, 3, 32'hDEAD_BEEF);
      do_op(5, 5'd4, 32'h203, 32'h0000_00A5, 0, 1, 32'h0);
      do_op(3, 5'd6, 32'h102, 32'h0, 1, 1, 32'h1234_5678);
      do_op(4, 5'd2, 32'h401, 32'hCAFE_F00D, 0, 1, 32'h0);
      do_op(6, 5'd3, 32'h5, 32'h0, 0, 1, 32'h0);

      // Reset asserted while waiting for read data; the late rvalid must be dropped.
      valid_i   = 1'b1;
      op_i      = 3'd2;
      rd_addr_i = 5'd7;
      result_i  = 32'h300;
      @(negedge clk);
      valid_i    = 1'b0;
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      dmem_gnt_i = 1'b0;
      check("rw_wait_ready", 32'(ready_o), 32'd0);
      n_reset_i = 1'b0;
      #1;
      check("rw_ready", 32'(ready_o), 32'd1);
      check("rw_req", 32'(dmem_req_o), 32'd0);
      check("rw_addr", 32'(dmem_addr_o), 32'd0);
      check("rw_wb_we", 32'(wb_we_o), 32'd0);
      @(negedge clk);
      n_reset_i     = 1'b1;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h5555_AAAA;
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
      check("rw_late_rvalid", 32'(wb_we_o), 32'd0);
      check("rw_ready_after", 32'(ready_o), 32'd1);

      // Random transactions.
      for (int n = 0; n < 60; n++) begin
         do_op(int'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback stage of the miner core, directly downstream of the ALU. It takes the ALU result (data or effective address), store data and a decoded op class from execute. It performs word/byte loads and stores over a simple request/grant/rvalid data-memory port, then presents one registered writeback per instruction to the register file. While a memory access is outstanding it back-pressures execute via `ready_o`.

## Interface
Parameters:
- `REG_AW`, default 5: register-file address width.
- `ADDR_W`, default 32: data-memory byte-address width (≤ 32).

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `n_reset_i`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  execute presents an instruction this cycle.
- `ready_o`  out  1  stage can accept; transfer occurs when `valid_i & ready_o`.
- `op_i`  in  3  op class: 0 NONE, 1 ALU, 2 LW, 3 LBU, 4 SW, 5 SB, 6–7 treated as NONE.
- `rd_addr_i`  in  REG_AW  destination register.
- `result_i`  in  32  ALU result; for memory ops, the byte address.
- `store_data_i`  in  32  store operand (rs).
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  ADDR_W  byte address; bits [1:0] are forced to 0.
- `dmem_be_o`  out  4  byte enables, little-endian.
- `dmem_wdata_o`  out  32  write data.
- `dmem_gnt_i`  in  1  request accepted this cycle.
- `dmem_rvalid_i`  in  1  read data valid; arrives at least one cycle after grant.
- `dmem_rdata_i`  in  32  read data.
- `wb_we_o`  out  1  one-cycle register-file write strobe.
- `wb_addr_o`  out  REG_AW  writeback register.
- `wb_data_o`  out  32  writeback data.
- `misalign_o`  out  1  one-cycle pulse: word op with `result_i[1:0] != 0`.

## Operation
- FSM states:
  - IDLE: `ready_o=1`.
  - REQ: `dmem_req_o=1`, `ready_o=0`.
  - WAIT: load only; `ready_o=0`.
- IDLE, accepted NONE: no writeback; remain in IDLE.
- IDLE, accepted ALU: register `wb_we_o=1`, `wb_addr_o=rd_addr_i`, `wb_data_o=result_i`; remain in IDLE.
- IDLE, accepted LW/LBU/SW/SB: capture op, `rd_addr_i`, address and store data; go to REQ.
- REQ: hold all `dmem_*` outputs stable until `dmem_gnt_i`.
  - Store granted: go to IDLE.
  - Load granted: go to WAIT.
- WAIT: on `dmem_rvalid_i`, register the writeback and go to IDLE. `ready_o` rises in the same cycle as the writeback strobe.
- Word ops: `dmem_be_o=4'hF`; `dmem_wdata_o=store_data`.
  - Misaligned word ops still execute at the masked address.
  - `misalign_o` pulses in the cycle after acceptance.
- Byte ops (`b = addr[1:0]`): `dmem_be_o = 4'b0001 << b`; `dmem_wdata_o = {4{store_data[7:0]}}`.
- LBU writeback: `{24'b0, rdata[8b+7:8b]}`.
- `dmem_rvalid_i` or `dmem_gnt_i` arriving outside the expected state is ignored.

## Timing
- Reset values: state IDLE; `ready_o=1`. The following outputs are 0: `dmem_req_o`, `dmem_we_o`, `wb_we_o`, `misalign_o`, `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`, `wb_addr_o`, `wb_data_o`.
- ALU op: `wb_we_o` asserts in cycle T+1 after acceptance in cycle T. Throughput is one per cycle.
- Memory ops: `dmem_req_o` first asserts in cycle T+1.
  - Store grant in T+1 → `ready_o` in T+2. Store throughput is therefore one per 2 cycles minimum.
  - Load with grant in cycle G and rvalid in cycle R > G: `wb_we_o` asserts in R+1.
- `wb_we_o` and `misalign_o` are single-cycle pulses and deassert the following cycle.
- Reset asserted mid-access: the stage immediately returns to reset values, and any later rvalid is ignored.

## Configuration
- `MEM_WB_BYTE_OPS_EN`:
  - Defined: LBU/SB behave as described above.
  - Undefined: LBU executes as LW and SB as SW (full-word, `dmem_be_o=4'hF`), including the misalign check. The byte-lane logic is absent.

## Test plan
- Reset: hold `n_reset_i=0` → `ready_o=1`, all other outputs 0; release → no spurious `dmem_req_o`.
- ALU stream: 3 back-to-back ALU ops (rd 1/2/3; data 0x11/0x22/0x33) → `wb_we_o` on 3 consecutive cycles with matching addr/data; `ready_o` stays 1.
- LW at 0x100, grant after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF → `dmem_be_o=F`, addr 0x100, `ready_o=0` throughout; `wb_data_o=0xDEADBEEF` one cycle after rvalid; then `ready_o=1`.
- SB at 0x203 with data 0x000000A5, immediate grant → `dmem_be_o=4'b1000`, `dmem_wdata_o=0xA5A5A5A5`, `dmem_addr_o=0x200`; no writeback.
- LBU at 0x102, rdata 0x12345678 → `wb_data_o=0x00000034`. With the macro undefined → `wb_data_o=0x12345678`, and `misalign_o` pulses.
- Reset during WAIT, then rvalid → no `wb_we_o`; `ready_o=1` after reset release.
